bbox_stats: RTL and testbench
=============================

Name: bbox_stats

Overview:
- Sits directly downstream of the connected-components labeller.
- Consumes the per-pixel resolved label stream, one pixel per `en` cycle, framed by hsync/vsync.
- Accumulates per-label bounding box (min/max x, min/y, max y) and pixel area over one frame.
- After end of frame, drains the table as a valid/ready record stream for overlay/readout logic.

Parameters:
- LABEL_W, 8: label width; the table holds 2^LABEL_W entries; label 0 is background.
- X_W, 10: column counter width.
- Y_W, 10: row counter width.
- AREA_W, 20: area counter width; saturates at the maximum value.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  pixel valid; one pixel per cycle when high.
- hsync  in  1  high with the first pixel of each row (qualified by en).
- vsync  in  1  high with the first pixel of a frame (qualified by en); overrides hsync.
- label  in  LABEL_W  resolved label of the current pixel.
- eof  in  1  one-cycle end-of-frame pulse; may coincide with the last pixel.
- out_valid  out  1  record available.
- out_ready  in  1  consumer accepts the record.
- out_label  out  LABEL_W  label of the record.
- out_min_x, out_max_x  out  X_W  column bounds.
- out_min_y, out_max_y  out  Y_W  row bounds.
- out_area  out  AREA_W  pixel count.
- busy  out  1  high in DRAIN/DUMP; pixels are ignored while high.
- frame_done  out  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset:
  - State goes to IDLE; all table entries invalid.
  - x = 0, y = 0.
  - out_valid, busy and frame_done are 0; all data outputs are 0.
- Coordinates:
  - en & vsync: pixel is at (0,0).
  - en & hsync & !vsync: x = 0, y += 1.
  - en otherwise: x += 1.
  - x and y saturate at all-ones.
- State machine:
  - IDLE: en & vsync goes to ACCUM; that pixel is accumulated.
  - ACCUM: every en pixel with label != 0 updates its entry. eof goes to DRAIN. A pixel in the same cycle as eof is accumulated.
  - DRAIN: lasts exactly 2 cycles, to flush the update pipeline, then goes to DUMP.
  - DUMP: scans labels 1 .. 2^LABEL_W-1 in ascending order and emits valid entries only. When the scan completes, all entries are invalidated in one cycle, frame_done pulses, and the state goes to IDLE.
- vsync during ACCUM without a preceding eof:
  - Discards the table (all entries invalidated).
  - Restarts accumulation at (0,0) with that pixel.
- Entry update:
  - First hit on an invalid entry: min = max = (x,y), area = 1, entry becomes valid.
  - Later hits: min/max updated per coordinate; area += 1, saturating.
- Update pipeline:
  - 2 stages: read, then modify/write.
  - Back-to-back pixels with the same label must produce results identical to a purely sequential update; use write-forwarding.
  - A pixel at cycle n is visible in the table by cycle n+2.
- Output handshake:
  - Record fields are stable while out_valid=1 and out_ready=0.
  - A transfer occurs when out_valid & out_ready. The next record may be presented in the following cycle, so the throughput is 1 per cycle with out_ready held high.
  - out_valid never depends combinationally on out_ready.
- Empty frame (no valid entries): DUMP emits nothing; frame_done still pulses.
- busy is high from the cycle after eof until the frame_done cycle inclusive. en/vsync/eof are ignored while busy.
- Reset mid-ACCUM or mid-DUMP:
  - Next cycle is IDLE with the table invalidated.
  - out_valid=0; any partial dump is discarded.
- eof in IDLE: ignored.

Decomposition:
- Shared package `detect_pkg`:
  - LABEL_W, X_W, Y_W, AREA_W defaults.
  - Packed struct `bbox_t` {min_x, max_x, min_y, max_y, area, vld}.
  - State enum {IDLE, ACCUM, DRAIN, DUMP}.
- Sub-module `bbox_table`:
  - 2^LABEL_W-entry `bbox_t` storage.
  - One read port and one write port, plus a single-cycle bulk invalidate.
  - Owns the update/forwarding pipeline.
- `bbox_stats` owns the coordinate counters, the FSM and the dump/handshake.

Test Plan:
- Single object:
  - Stimulus: 8x4 frame; label 5 at (2,1),(3,1),(2,2); eof with the last pixel.
  - Response: exactly one record {5, 2,3, 1,2, area 3}, then frame_done.
- Back-to-back same label:
  - Stimulus: row 0 all label 7 for x=0..7.
  - Response: record {7, 0,7, 0,0, area 8}; confirms forwarding.
- Multi-label ordering with backpressure:
  - Stimulus: labels 9, 2 and 200 present; out_ready toggled 1,0,0,1,...
  - Response: records emitted in order 2, 9, 200; fields held while stalled; no duplicates or losses.
- Empty frame:
  - Stimulus: all labels 0.
  - Response: out_valid never asserts; frame_done pulses once after DRAIN plus the scan.
- Area saturation:
  - Stimulus: AREA_W=4; 20 pixels of label 1.
  - Response: out_area=15.
- Reset in DUMP and vsync restart:
  - Reset asserted mid-dump: out_valid=0 next cycle; the next frame with label 3 at (0,0) only yields {3,0,0,0,0,1} with no stale entries.
  - vsync mid-ACCUM: the prior partial frame's labels are absent from the dump.

Source files
------------

// File: rtl/detect_pkg.sv
// Shared types for the label-statistics path: default widths, the per-label
// bounding-box record and the bbox_stats state encoding.
package detect_pkg;

    localparam int unsigned DEF_LABEL_W = 8;
    localparam int unsigned DEF_X_W     = 10;
    localparam int unsigned DEF_Y_W     = 10;
    localparam int unsigned DEF_AREA_W  = 20;

    // Fields are sized to the defaults; instances may use narrower widths.
    typedef struct packed {
        logic [DEF_X_W-1:0]    min_x;
        logic [DEF_X_W-1:0]    max_x;
        logic [DEF_Y_W-1:0]    min_y;
        logic [DEF_Y_W-1:0]    max_y;
        logic [DEF_AREA_W-1:0] area;
        logic                  vld;
    } bbox_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DUMP
    } state_t;

    // Fold one pixel into an entry; an invalid entry starts fresh.
    function automatic bbox_t bbox_merge(input bbox_t e,
                                         input logic [DEF_X_W-1:0] x,
                                         input logic [DEF_Y_W-1:0] y,
                                         input logic [DEF_AREA_W-1:0] area_max);
        bbox_t r;
        if (!e.vld) begin
            r.min_x = x;
            r.max_x = x;
            r.min_y = y;
            r.max_y = y;
            r.area  = DEF_AREA_W'(1);
            r.vld   = 1'b1;
        end else begin
            r       = e;
            r.min_x = (x < e.min_x) ? x : e.min_x;
            r.max_x = (x > e.max_x) ? x : e.max_x;
            r.min_y = (y < e.min_y) ? y : e.min_y;
            r.max_y = (y > e.max_y) ? y : e.max_y;
            r.area  = (e.area >= area_max) ? area_max : e.area + DEF_AREA_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/bbox_table.sv
// Per-label bounding-box storage with a read / modify-write update pipeline,
// write forwarding for back-to-back hits and a one-cycle bulk invalidate.
module bbox_table
    import detect_pkg::*;
#(
    parameter int unsigned LABEL_W = DEF_LABEL_W,
    parameter int unsigned X_W     = DEF_X_W,
    parameter int unsigned Y_W     = DEF_Y_W,
    parameter int unsigned AREA_W  = DEF_AREA_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               upd_en,
    input  logic [LABEL_W-1:0] upd_label,
    input  logic [X_W-1:0]     upd_x,
    input  logic [Y_W-1:0]     upd_y,
    input  logic [LABEL_W-1:0] rd_addr,
    output bbox_t              rd_data
);

    localparam int unsigned DEPTH = 2 ** LABEL_W;
    localparam logic [DEF_AREA_W-1:0] AREA_MAX = DEF_AREA_W'((64'd1 << AREA_W) - 64'd1);

    bbox_t              mem [DEPTH];
    logic [DEPTH-1:0]   vld_q;

    logic               s1_vld;
    logic [LABEL_W-1:0] s1_label;
    logic [X_W-1:0]     s1_x;
    logic [Y_W-1:0]     s1_y;
    bbox_t              s1_ent;

    logic [LABEL_W-1:0] rd_sel;
    bbox_t              wr_ent;
    logic               wr_en;

    // The single read port serves the update pipeline first, the dump otherwise.
    assign rd_sel = upd_en ? upd_label : rd_addr;

    always_comb begin
        rd_data     = mem[rd_sel];
        rd_data.vld = vld_q[rd_sel];
    end

    assign wr_ent = bbox_merge(s1_ent, DEF_X_W'(s1_x), DEF_Y_W'(s1_y), AREA_MAX);
    assign wr_en  = s1_vld && !clr && !reset;

    // Read stage; a clear kills the in-flight write and starts the new pixel fresh.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld   <= 1'b0;
            s1_label <= '0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_ent   <= '0;
            vld_q    <= '0;
        end else begin
            s1_vld   <= upd_en;
            s1_label <= upd_label;
            s1_x     <= upd_x;
            s1_y     <= upd_y;
            if (clr) begin
                s1_ent <= '0;
            end else if (wr_en && (s1_label == upd_label)) begin
                s1_ent <= wr_ent;
            end else begin
                s1_ent <= rd_data;
            end
            if (clr) begin
                vld_q <= '0;
            end else if (wr_en) begin
                vld_q[s1_label] <= 1'b1;
            end
        end
    end

    // Data array carries no reset; the valid vector qualifies every entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[s1_label] <= wr_ent;
        end
    end

endmodule

// File: rtl/bbox_stats.sv
// Per-frame label statistics: tracks pixel coordinates, accumulates bounding
// boxes and area per label, then drains valid entries as a valid/ready stream.
module bbox_stats
    import detect_pkg::*;
#(
    parameter int unsigned LABEL_W = DEF_LABEL_W,
    parameter int unsigned X_W     = DEF_X_W,
    parameter int unsigned Y_W     = DEF_Y_W,
    parameter int unsigned AREA_W  = DEF_AREA_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               hsync,
    input  logic               vsync,
    input  logic [LABEL_W-1:0] label,
    input  logic               eof,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LABEL_W-1:0] out_label,
    output logic [X_W-1:0]     out_min_x,
    output logic [X_W-1:0]     out_max_x,
    output logic [Y_W-1:0]     out_min_y,
    output logic [Y_W-1:0]     out_max_y,
    output logic [AREA_W-1:0]  out_area,
    output logic               busy,
    output logic               frame_done
);

    state_t             state;
    logic [X_W-1:0]     x_cnt;
    logic [Y_W-1:0]     y_cnt;
    logic [X_W-1:0]     px;
    logic [Y_W-1:0]     py;
    logic               drain_cnt;
    logic [LABEL_W-1:0] scan_idx;
    logic               scan_done;

    logic               accept;
    logic               restart;
    logic               upd_en;
    logic               slot_free;
    logic               dump_end;
    logic               clr;
    bbox_t              rd_data;

    // Coordinate of the pixel currently on the input.
    always_comb begin
        px = (x_cnt == '1) ? x_cnt : x_cnt + X_W'(1);
        py = y_cnt;
        if (vsync) begin
            px = '0;
            py = '0;
        end else if (hsync) begin
            px = '0;
            py = (y_cnt == '1) ? y_cnt : y_cnt + Y_W'(1);
        end
    end

    assign accept    = en && !busy && (((state == IDLE) && vsync) || (state == ACCUM));
    assign restart   = en && !busy && vsync && (state == ACCUM);
    assign upd_en    = accept && (label != '0);
    assign slot_free = !out_valid || out_ready;
    assign dump_end  = (state == DUMP) && scan_done && slot_free;
    assign clr       = restart || dump_end;

    bbox_table #(
        .LABEL_W (LABEL_W),
        .X_W     (X_W),
        .Y_W     (Y_W),
        .AREA_W  (AREA_W)
    ) u_table (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .upd_en    (upd_en),
        .upd_label (label),
        .upd_x     (px),
        .upd_y     (py),
        .rd_addr   (scan_idx),
        .rd_data   (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            x_cnt      <= '0;
            y_cnt      <= '0;
            drain_cnt  <= 1'b0;
            scan_idx   <= '0;
            scan_done  <= 1'b0;
            out_valid  <= 1'b0;
            out_label  <= '0;
            out_min_x  <= '0;
            out_max_x  <= '0;
            out_min_y  <= '0;
            out_max_y  <= '0;
            out_area   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (en && !busy) begin
                x_cnt <= px;
                y_cnt <= py;
            end
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (accept) begin
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (eof) begin
                        state     <= DRAIN;
                        busy      <= 1'b1;
                        drain_cnt <= 1'b0;
                    end
                end
                DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        state     <= DUMP;
                        scan_idx  <= LABEL_W'(1);
                        scan_done <= 1'b0;
                    end
                end
                DUMP: begin
                    // busy stays high through the frame_done cycle.
                    if (dump_end) begin
                        out_valid  <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end else if (!scan_done && slot_free) begin
                        out_valid <= rd_data.vld;
                        if (rd_data.vld) begin
                            out_label <= scan_idx;
                            out_min_x <= X_W'(rd_data.min_x);
                            out_max_x <= X_W'(rd_data.max_x);
                            out_min_y <= Y_W'(rd_data.min_y);
                            out_max_y <= Y_W'(rd_data.max_y);
                            out_area  <= AREA_W'(rd_data.area);
                        end
                        if (scan_idx == '1) begin
                            scan_done <= 1'b1;
                        end else begin
                            scan_idx <= scan_idx + LABEL_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bbox_stats.sv
// Directed bench for bbox_stats: 8-wide frames from a label map, records
// collected under configurable backpressure and compared to hand values.
module tb_bbox_stats;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       hsync = 1'b0;
    logic       vsync = 1'b0;
    logic [7:0] label = '0;
    logic       eof = 1'b0;
    logic       out_ready = 1'b0;

    logic        out_valid, busy, frame_done;
    logic [7:0]  out_label;
    logic [9:0]  out_min_x, out_max_x, out_min_y, out_max_y;
    logic [19:0] out_area;

    logic        sat_valid, sat_busy, sat_frame_done;
    logic [7:0]  sat_label;
    logic [9:0]  sat_min_x, sat_max_x, sat_min_y, sat_max_y;
    logic [3:0]  sat_area;

    typedef struct packed {
        logic [7:0]  lbl;
        logic [9:0]  min_x;
        logic [9:0]  max_x;
        logic [9:0]  min_y;
        logic [9:0]  max_y;
        logic [19:0] area;
        logic [3:0]  sat_area;
    } rec_t;

    rec_t       got[$];
    logic [7:0] fmap [4][8];
    int         checks = 0;
    int         failures = 0;
    int         fd_cnt;
    int         fd_at;
    logic       vld_seen;

    always #5 clk = ~clk;

    bbox_stats dut (
        .clk(clk), .reset(reset), .en(en), .hsync(hsync), .vsync(vsync),
        .label(label), .eof(eof), .out_valid(out_valid), .out_ready(out_ready),
        .out_label(out_label), .out_min_x(out_min_x), .out_max_x(out_max_x),
        .out_min_y(out_min_y), .out_max_y(out_max_y), .out_area(out_area),
        .busy(busy), .frame_done(frame_done)
    );

    bbox_stats #(.AREA_W(4)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .hsync(hsync), .vsync(vsync),
        .label(label), .eof(eof), .out_valid(sat_valid), .out_ready(out_ready),
        .out_label(sat_label), .out_min_x(sat_min_x), .out_max_x(sat_max_x),
        .out_min_y(sat_min_y), .out_max_y(sat_max_y), .out_area(sat_area),
        .busy(sat_busy), .frame_done(sat_frame_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_map();
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++)
                fmap[y][x] = 8'd0;
    endtask

    // Stream rows 0..rows-1 of the map; eof rides on the last pixel when asked.
    task automatic send_frame(input int rows, input bit do_eof);
        for (int y = 0; y < rows; y++) begin
            for (int x = 0; x < 8; x++) begin
                en    = 1'b1;
                vsync = (x == 0) && (y == 0);
                hsync = (x == 0);
                label = fmap[y][x];
                eof   = do_eof && (y == rows - 1) && (x == 7);
                tick();
            end
        end
        en = 1'b0; vsync = 1'b0; hsync = 1'b0; eof = 1'b0; label = '0;
    endtask

    // Capture transfers until frame_done (plus a few cycles), checking stall holds.
    task automatic collect(input int mode);
        logic        r;
        logic        stall;
        logic [7:0]  held_l;
        logic [59:0] held_f;
        rec_t        rec;
        got.delete();
        fd_cnt = 0; fd_at = -1; vld_seen = 1'b0; stall = 1'b0;
        held_l = '0; held_f = '0;
        for (int c = 0; c < 2000; c++) begin
            r = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
            out_ready = r;
            if (stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_label", out_label, held_l);
                check("hold_fields", {out_min_x, out_max_x, out_min_y, out_max_y, out_area}, held_f);
            end
            if (out_valid) vld_seen = 1'b1;
            if (out_valid && r) begin
                rec = '{out_label, out_min_x, out_max_x, out_min_y, out_max_y, out_area, sat_area};
                got.push_back(rec);
            end
            stall  = out_valid && !r;
            held_l = out_label;
            held_f = {out_min_x, out_max_x, out_min_y, out_max_y, out_area};
            if (frame_done) begin
                fd_cnt++;
                if (fd_at < 0) fd_at = c;
            end
            tick();
            if (fd_at >= 0 && c >= fd_at + 4) break;
        end
        out_ready = 1'b0;
        check("fd_count", fd_cnt, 1);
        check("busy_after_done", busy, 0);
    endtask

    task automatic check_rec(input int idx, input logic [7:0] l, input int mnx, input int mxx,
                             input int mny, input int mxy, input int area);
        if (idx < got.size()) begin
            check("rec_label", got[idx].lbl, l);
            check("rec_min_x", got[idx].min_x, mnx);
            check("rec_max_x", got[idx].max_x, mxx);
            check("rec_min_y", got[idx].min_y, mny);
            check("rec_max_y", got[idx].max_y, mxy);
            check("rec_area",  got[idx].area, area);
        end else begin
            check("rec_missing", 0, 1);
        end
    endtask

    task automatic map_multi();
        clear_map();
        fmap[0][1] = 8'd9;   fmap[3][4] = 8'd9;
        fmap[1][6] = 8'd2;
        fmap[2][0] = 8'd200; fmap[2][7] = 8'd200; fmap[3][3] = 8'd200;
    endtask

    initial begin
        bit seen;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_out_label", out_label, 0);
        check("rst_out_area", out_area, 0);
        repeat (2) tick();

        // Single object
        clear_map();
        fmap[1][2] = 8'd5; fmap[1][3] = 8'd5; fmap[2][2] = 8'd5;
        send_frame(4, 1);
        check("busy_after_eof", busy, 1);
        collect(0);
        check("single_count", got.size(), 1);
        check_rec(0, 8'd5, 2, 3, 1, 2, 3);
        repeat (2) tick();

        // Back-to-back same label across row 0
        clear_map();
        for (int x = 0; x < 8; x++) fmap[0][x] = 8'd7;
        send_frame(4, 1);
        collect(0);
        check("row_count", got.size(), 1);
        check_rec(0, 8'd7, 0, 7, 0, 0, 8);
        repeat (2) tick();

        // Ordering under backpressure
        map_multi();
        send_frame(4, 1);
        collect(1);
        check("multi_count", got.size(), 3);
        check_rec(0, 8'd2, 6, 6, 1, 1, 1);
        check_rec(1, 8'd9, 1, 4, 0, 3, 2);
        check_rec(2, 8'd200, 0, 7, 2, 3, 3);
        repeat (2) tick();

        // Empty frame
        clear_map();
        send_frame(4, 1);
        collect(0);
        check("empty_count", got.size(), 0);
        check("empty_no_valid", vld_seen, 0);
        check("empty_fd_latency", (fd_at >= 257) && (fd_at <= 259), 1);
        repeat (2) tick();

        // Area saturation (20 pixels of label 1)
        clear_map();
        for (int i = 0; i < 20; i++) fmap[i / 8][i % 8] = 8'd1;
        send_frame(4, 1);
        collect(0);
        check("sat_count", got.size(), 1);
        check_rec(0, 8'd1, 0, 7, 0, 2, 20);
        if (got.size() > 0) check("sat_area4", got[0].sat_area, 15);
        repeat (2) tick();

        // Reset in the middle of a stalled dump
        map_multi();
        send_frame(4, 1);
        out_ready = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            if (out_valid) seen = 1'b1;
            else tick();
        end
        check("dump_started", seen, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_busy", busy, 0);
        repeat (2) tick();
        clear_map();
        fmap[0][0] = 8'd3;
        send_frame(4, 1);
        collect(0);
        check("post_rst_count", got.size(), 1);
        check_rec(0, 8'd3, 0, 0, 0, 0, 1);
        repeat (2) tick();

        // vsync restart mid-accumulation; label 6 straddles the restart
        clear_map();
        fmap[0][1] = 8'd50; fmap[1][3] = 8'd50; fmap[1][7] = 8'd6;
        send_frame(2, 0);
        clear_map();
        fmap[0][0] = 8'd6; fmap[1][2] = 8'd4;
        send_frame(4, 1);
        collect(0);
        check("restart_count", got.size(), 2);
        check_rec(0, 8'd4, 2, 2, 1, 1, 1);
        check_rec(1, 8'd6, 0, 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
